// File: rtl/stream_pkg.sv
// Shared definitions for the serial stream path: word width default,
// FIFO level sizing and bit-order encoding used by packer and serializer.
package stream_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic {
    BIT_ORDER_LSB_FIRST = 1'b0,
    BIT_ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  // Level counter width able to hold 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head-of-queue data and registered
// full/empty flags; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
  import stream_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                pop_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next_c;
  logic [LVL_W-1:0] level_next_c;
  logic [W-1:0]     head_next_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Next head is either the stored word or the one being written right now.
  always_comb begin
    pop_ok_c     = pop && !empty;
    push_ok_c    = push && (!full || pop_ok_c);
    rd_next_c    = rd_ptr + PTR_W'(pop_ok_c);
    level_next_c = level + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
    head_next_c  = (push_ok_c && (wr_ptr == rd_next_c)) ? push_data : mem[rd_next_c];
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pop_data <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_ok_c);
      rd_ptr <= rd_next_c;
      level  <= level_next_c;
      full   <= (level_next_c == LVL_W'(DEPTH));
      empty  <= (level_next_c == '0);
      if (level_next_c != '0) begin
        pop_data <= head_next_c;
      end
    end
  end

endmodule

// File: rtl/serial_word_packer.sv
// Collects a gated 1-bit stream into DATA_W-bit words, queues them in a
// small FIFO for a valid/ready consumer and flags words lost to a full FIFO.
module serial_word_packer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             i_d,
  input  logic                             i_flush,
  output logic [DATA_W-1:0]                o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [level_w(FIFO_DEPTH)-1:0]   o_level,
  output logic                             o_overflow
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam bit_order_e  ORDER = (MSB_FIRST != 0) ? BIT_ORDER_MSB_FIRST : BIT_ORDER_LSB_FIRST;

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_next_c;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next_c;
  logic [DATA_W-1:0] shifted_c;
  logic              word_done_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;

  // Collector: bit_cnt walks 0..DATA_W-1; the last-bit edge emits the word.
  always_comb begin
    bit_cnt_next_c = bit_cnt;
    shreg_next_c   = shreg;
    word_done_c    = 1'b0;
    if (ORDER == BIT_ORDER_MSB_FIRST) begin
      shifted_c = {shreg[DATA_W-2:0], i_d};
    end else begin
      shifted_c = {i_d, shreg[DATA_W-1:1]};
    end
    if (i_flush) begin
      bit_cnt_next_c = '0;
      shreg_next_c   = '0;
    end else if (en) begin
      if (bit_cnt == CNT_W'(DATA_W - 1)) begin
        word_done_c    = 1'b1;
        bit_cnt_next_c = '0;
        shreg_next_c   = '0;
      end else begin
        bit_cnt_next_c = bit_cnt + CNT_W'(1);
        shreg_next_c   = shifted_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      bit_cnt <= bit_cnt_next_c;
      shreg   <= shreg_next_c;
    end
  end

  assign pop_c   = o_valid && i_ready;
  assign o_valid = !fifo_empty;

  // Sticky drop flag: a word completed into a full FIFO with no pop to make room.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_overflow <= 1'b0;
    end else if (word_done_c && fifo_full && !pop_c) begin
      o_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (word_done_c),
    .push_data (shifted_c),
    .pop       (pop_c),
    .pop_data  (o_data),
    .level     (o_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_serial_word_packer.sv
// Scoreboard bench: one MSB-first and one LSB-first packer share stimulus;
// expected words are queued at issue time and popped by per-DUT monitors.
module tb_serial_word_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       i_d;
  logic       i_flush;
  logic       i_ready;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic [2:0] m_level, l_level;
  logic       m_ovf, l_ovf;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  always #5 clk = ~clk;

  serial_word_packer #(.DATA_W(8), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .i_d(i_d), .i_flush(i_flush),
    .o_data(m_data), .o_valid(m_valid), .i_ready(i_ready),
    .o_level(m_level), .o_overflow(m_ovf)
  );

  serial_word_packer #(.DATA_W(8), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .i_d(i_d), .i_flush(i_flush),
    .o_data(l_data), .o_valid(l_valid), .i_ready(i_ready),
    .o_level(l_level), .o_overflow(l_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every accepted transfer is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && i_ready === 1'b1) begin
      if (exp_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL msb_word: unexpected word 0x%0h", m_data);
      end else begin
        chk("msb_word", 32'(m_data), 32'(exp_m.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && l_valid === 1'b1 && i_ready === 1'b1) begin
      if (exp_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lsb_word: unexpected word 0x%0h", l_data);
      end else begin
        chk("lsb_word", 32'(l_data), 32'(exp_l.pop_front()));
      end
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    en      = 1'b1;
    i_d     = b;
    i_flush = 1'b0;
    step();
    en      = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) send_bit(w[k]);
  endtask

  task automatic expect_word(input logic [7:0] w);
    exp_m.push_back(w);
    exp_l.push_back(rev8(w));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    i_ready = 1'b1;
    en      = 1'b0;
    for (int k = 0; k < 20 && (exp_m.size() != 0 || exp_l.size() != 0); k++) step();
    step();
    chk({name, "_msb_pending"}, 32'(exp_m.size()), 32'd0);
    chk({name, "_lsb_pending"}, 32'(exp_l.size()), 32'd0);
    chk({name, "_msb_level"}, 32'(m_level), 32'd0);
    chk({name, "_lsb_level"}, 32'(l_level), 32'd0);
  endtask

  initial begin
    logic       hist [8];
    logic [7:0] wm;
    int         n;
    logic [7:0] w;

    rst_n = 1'b0; en = 1'b0; i_d = 1'b0; i_flush = 1'b0; i_ready = 1'b1;

    // Reset held with active stream: outputs must stay idle.
    for (int c = 0; c < 5; c++) begin
      en  = 1'b1;
      i_d = c[0];
      step();
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_level", 32'(m_level), 32'd0);
      chk("rst_ovf", 32'(m_ovf), 32'd0);
      chk("rst_lsb_valid", 32'(l_valid), 32'd0);
    end
    chk("rst_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (3) begin
      step();
      chk("idle_no_word", 32'(m_valid | l_valid), 32'd0);
    end

    // 0xA5: palindromic for both bit orders; valid one cycle after last bit.
    expect_word(8'hA5);
    send_word(8'hA5);
    chk("a5_valid_msb", 32'(m_valid), 32'd1);
    chk("a5_valid_lsb", 32'(l_valid), 32'd1);
    chk("a5_data_msb", 32'(m_data), 32'hA5);
    step();
    chk("a5_single_cycle", 32'(m_valid | l_valid), 32'd0);

    // 1,1,0,0,0,0,0,0 -> 0xC0 MSB-first, 0x03 LSB-first.
    exp_m.push_back(8'hC0);
    exp_l.push_back(8'h03);
    send_word(8'hC0);
    repeat (2) step();

    // Pause mid-word: 1,0,1 / idle 4 / 1,0,0,1,1.
    exp_m.push_back(8'hB3);
    exp_l.push_back(8'hCD);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4) step();
    chk("pause_no_word", 32'(m_valid), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (2) step();

    // Flush after 5 bits; only the following 0xFF may appear.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    en = 1'b1; i_d = 1'b1; i_flush = 1'b1;
    step();
    i_flush = 1'b0; en = 1'b0;
    chk("flush_level", 32'(m_level), 32'd0);
    chk("flush_valid", 32'(m_valid), 32'd0);
    expect_word(8'hFF);
    send_word(8'hFF);
    drain("flush");

    // Backpressure: five words into a four-deep FIFO, fifth dropped.
    i_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      w = 8'(v);
      if (v <= 4) expect_word(w);
      send_word(w);
      if (v == 2) chk("bp_head_early", 32'(m_data), 32'h01);
    end
    chk("bp_level_msb", 32'(m_level), 32'd4);
    chk("bp_level_lsb", 32'(l_level), 32'd4);
    chk("bp_ovf_msb", 32'(m_ovf), 32'd1);
    chk("bp_ovf_lsb", 32'(l_ovf), 32'd1);
    chk("bp_head_lsb", 32'(l_data), 32'h80);
    repeat (3) step();
    chk("bp_head_stable", 32'(m_data), 32'h01);
    chk("bp_valid_stable", 32'(m_valid), 32'd1);
    drain("bp");
    chk("bp_ovf_sticky", 32'(m_ovf), 32'd1);

    // Full FIFO with a pop on the edge the fifth word completes.
    do_reset(2);
    chk("full_ovf_cleared", 32'(m_ovf), 32'd0);
    i_ready = 1'b0;
    expect_word(8'h11); send_word(8'h11);
    expect_word(8'h22); send_word(8'h22);
    expect_word(8'h33); send_word(8'h33);
    expect_word(8'h44); send_word(8'h44);
    chk("full_level", 32'(m_level), 32'd4);
    expect_word(8'h55);
    w = 8'h55;
    for (int k = 7; k >= 1; k--) send_bit(w[k]);
    i_ready = 1'b1;
    send_bit(w[0]);
    i_ready = 1'b0;
    chk("full_pass_level", 32'(m_level), 32'd4);
    chk("full_pass_ovf_msb", 32'(m_ovf), 32'd0);
    chk("full_pass_ovf_lsb", 32'(l_ovf), 32'd0);
    chk("full_pass_head", 32'(m_data), 32'h22);
    drain("full");

    // Random soak against a bit-history reference packer.
    do_reset(2);
    n = 0;
    for (int c = 0; c < 64; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      en      = 1'b1;
      i_d     = 1'($urandom_range(0, 1));
      hist[n] = i_d;
      n++;
      if (n == 8) begin
        for (int k = 0; k < 8; k++) wm[7-k] = hist[k];
        expect_word(wm);
        n = 0;
      end
      step();
    end
    en = 1'b0;
    drain("soak");
    chk("soak_ovf", 32'(m_ovf | l_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
